// File: rtl/ram8_pkg.sv
// ram8_pkg: shared sizes, state enum and word type for the RAM8 register file.
package ram8_pkg;
    localparam int WIDTH_DEF = 16;
    localparam int ADDR_W    = 3;
    localparam int DEPTH     = 8;
    typedef enum logic {IDLE, CLEAR} ram8_state_t;
    typedef logic [WIDTH_DEF-1:0] ram8_word_t;
    typedef logic [ADDR_W-1:0] ram8_addr_t;
endpackage

// File: rtl/ram8_16bit_if.sv
// ram8_16bit_if: write/read/clear bus of the RAM8 register file.
interface ram8_16bit_if #(parameter int WIDTH = ram8_pkg::WIDTH_DEF);
    logic [WIDTH-1:0]            in;
    logic [WIDTH-1:0]            out;
    logic                        load;
    logic                        clr;
    logic                        busy;
    logic [ram8_pkg::ADDR_W-1:0] address;
    modport master (output in, load, address, clr, input out, busy);
    modport slave  (input in, load, address, clr, output out, busy);
endinterface

// File: rtl/ram8_16bit_load_demux8.sv
// load_demux8: turns a load strobe and 3-bit select into a one-hot write enable.
module load_demux8
    import ram8_pkg::*;
(
    input  logic              load,
    input  logic              en,
    input  logic [ADDR_W-1:0] sel,
    output logic [DEPTH-1:0]  we
);
    always_comb we = (load && en) ? ({{(DEPTH-1){1'b0}}, 1'b1} << sel) : '0;
endmodule

// File: rtl/ram8_16bit.sv
// ram8_16bit: 8x16 register file with a one-word-per-cycle bulk clear sequencer.
// Optional RAM8_BYPASS_EN forwards write data straight to out during an accepted write.
module ram8_16bit
    import ram8_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
)(
    input  logic         clk,
    input  logic         rst_n,
    ram8_16bit_if.slave  bus
);
    ram8_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [DEPTH-1:0]  we;
    logic              idle;

    assign idle = (state_q == IDLE);

    // clr takes priority over a same-cycle load, so the decode is masked by it
    load_demux8 u_demux (
        .load (bus.load),
        .en   (idle && !bus.clr),
        .sel  (bus.address),
        .we   (we)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        if (idle) begin
            if (bus.clr) begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
            for (int i = 0; i < DEPTH; i++)
                if (we[i]) mem_d[i] = bus.in;
        end else begin
            mem_d[cnt_q] = '0;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

`ifdef RAM8_BYPASS_EN
    always_comb bus.out = (bus.load && idle && !bus.clr) ? bus.in : mem_q[bus.address];
`else
    always_comb bus.out = mem_q[bus.address];
`endif

    always_comb bus.busy = !idle;
endmodule

// File: tb/tb_ram8_16bit.sv
// tb_ram8_16bit: directed and random stimulus against an array-based reference model.
module tb_ram8_16bit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram8_16bit_if #(.WIDTH(16)) bus ();
    ram8_16bit #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] m [8];
    int          clr_left;
    int          n_vec = 0;
    int          n_bad = 0;
    logic        last_busy;
    int          nb;

    function automatic logic [15:0] exp_out();
`ifdef RAM8_BYPASS_EN
        if (bus.load && clr_left == 0 && !bus.clr) return bus.in;
`endif
        return m[bus.address];
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = '0;
        clr_left = 0;
    endtask

    // one clock: apply inputs, check the pre-edge outputs, then advance the model at the edge
    task automatic cyc(input logic l, input logic [2:0] a, input logic [15:0] d, input logic c);
        bus.load = l; bus.address = a; bus.in = d; bus.clr = c;
        #1;
        chk("out", bus.out, exp_out());
        chk("busy", {15'b0, bus.busy}, {15'b0, clr_left > 0});
        last_busy = bus.busy;
        @(posedge clk);
        if (clr_left > 0) begin
            m[8 - clr_left] = '0;
            clr_left--;
        end else if (c) clr_left = 8;
        else if (l) m[a] = d;
        @(negedge clk);
    endtask

    task automatic rst_check();
        for (int a = 0; a < 8; a++) begin
            bus.address = 3'(a);
            #1;
            chk("rst_out", bus.out, 16'h0000);
            chk("rst_busy", {15'b0, bus.busy}, 16'h0000);
        end
    endtask

    initial begin
        bus.load = 0; bus.clr = 0; bus.in = '0; bus.address = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_check();
        rst_n = 1'b1;
        @(negedge clk);
        // reset asserted mid-operation
        for (int k = 0; k < 8; k++) cyc(1, 3'(k), 16'($urandom), 0);
        rst_n = 1'b0;
        model_reset();
        rst_check();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) cyc(0, 3'(k), 16'h0, 0);
        // write / readback, no aliasing
        for (int k = 0; k < 8; k++) cyc(1, 3'(k), 16'(16'h1111 * (k + 1)), 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 3'(k), 16'h0, 0);
            chk("readback", bus.out, 16'(16'h1111 * (k + 1)));
        end
        // write latency
        cyc(1, 3'd5, 16'hBEEF, 0);
        bus.load = 0;
        #1 chk("wr_lat", bus.out, 16'hBEEF);
        // full clear with a dropped write to address 2 mid-sweep
        for (int k = 0; k < 8; k++) cyc(1, 3'(k), 16'hFFFF, 0);
        cyc(0, 3'd0, 16'h0, 1);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) cyc(1, 3'd2, 16'h1234, 0);
            else cyc(0, 3'(i), 16'h0, 0);
            if (last_busy) nb++;
        end
        chk("busy_len", 16'(nb), 16'd8);
        for (int k = 0; k < 8; k++) begin
            cyc(0, 3'(k), 16'h0, 0);
            chk("cleared", bus.out, 16'h0000);
        end
        // load + clr in the same idle cycle, and a second clr mid-sweep
        for (int k = 0; k < 8; k++) cyc(1, 3'(k), 16'hA5A5, 0);
        cyc(1, 3'd4, 16'h5555, 1);
        nb = 0;
        for (int i = 0; i < 14; i++) begin
            cyc(0, 3'(i), 16'h0, i == 3);
            if (last_busy) nb++;
        end
        chk("busy_len_reclr", 16'(nb), 16'd8);
        cyc(0, 3'd4, 16'h0, 0);
        chk("clr_wins", bus.out, 16'h0000);
        // reset in the 4th clear cycle
        for (int k = 0; k < 8; k++) cyc(1, 3'(k), 16'($urandom) | 16'h1, 0);
        cyc(0, 3'd0, 16'h0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 3'(i), 16'h0, 0);
        rst_n = 1'b0;
        model_reset();
        rst_check();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 3'd6, 16'hABCD, 0);
        cyc(0, 3'd6, 16'h0, 0);
        chk("post_rst_wr", bus.out, 16'hABCD);
        // random traffic
        for (int i = 0; i < 1500; i++)
            cyc(1'($urandom), 3'($urandom), 16'($urandom), $urandom_range(0, 19) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
